rvc_fetch_aligner: RTL

Fetch-side aligner that turns a stream of word-aligned 32-bit memory fetches into a stream of variable-length RV32IC instructions. Each emitted instruction is either a full 32-bit instruction or a compressed 16-bit one. It sits between the instruction memory/cache port and the issue stage. Compressed halfwords go to the C-type decoder on `inst_out[15:0]`, and 32-bit words go to the base decoder. It owns the fetch PC, a 4-halfword buffer, one outstanding memory request, and redirect (flush) handling.

---
 rtl/rvc_fetch_aligner.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/rvc_fetch_aligner.sv
`default_nettype none
// ============================================================================
//  Module   : rvc_fetch_aligner
//  Purpose  : Turns word-aligned 32-bit fetches into a stream of RV32IC
//             instructions (16-bit compressed or 32-bit), tracking the fetch
//             PC, a 4-halfword queue, one outstanding request and redirects.
//  Revision : 1.0  initial release
// ============================================================================
module rvc_fetch_aligner #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        flush_in,
   input  logic [31:0] flush_pc_in,
   output logic        req_valid_out,
   output logic [31:0] req_addr_out,
   input  logic        req_ready_in,
   input  logic        resp_valid_in,
   input  logic [31:0] resp_data_in,
   output logic        inst_valid_out,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc_out,
   output logic        inst_is_c_out,
   input  logic        inst_ready_in
);

   localparam logic [31:0] c_reset_head  = {RESET_PC[31:1], 1'b0};
   localparam logic [31:0] c_reset_fetch = {RESET_PC[31:2], 2'b00};
   localparam logic        c_reset_skip  = RESET_PC[1];

   // registered state
   logic [15:0] buf_q [4];
   logic [15:0] buf_d [4];
   logic [2:0]  count_q, count_d;
   logic [31:0] head_pc_q, head_pc_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        skip_low_q, skip_low_d;
   logic        outstanding_q, outstanding_d;
   logic        discard_q, discard_d;

   // combinational helpers
   logic        w_head_c;
   logic        w_inst_avail;
   logic        w_consume;
   logic [2:0]  w_cons_n;
   logic        w_resp_take;
   logic [2:0]  w_app_n;
   logic [2:0]  w_base;
   logic [15:0] w_app0;
   logic [15:0] w_app1;
   logic        w_req_fire;
   logic [15:0] w_shift [4];

   // Head decode: low two bits != 11 mark a compressed instruction.
   assign w_head_c     = (buf_q[0][1:0] != 2'b11);
   assign w_inst_avail = w_head_c ? (count_q >= 3'd1) : (count_q >= 3'd2);
   assign w_consume    = w_inst_avail && inst_ready_in;
   assign w_cons_n     = !w_consume ? 3'd0 : (w_head_c ? 3'd1 : 3'd2);

   // A response is only appended when it belongs to the current stream.
   assign w_resp_take  = resp_valid_in && !discard_q;
   assign w_app_n      = !w_resp_take ? 3'd0 : (skip_low_q ? 3'd1 : 3'd2);
   assign w_app0       = skip_low_q ? resp_data_in[31:16] : resp_data_in[15:0];
   assign w_app1       = resp_data_in[31:16];
   assign w_base       = count_q - w_cons_n;

   // Requests are blocked during reset and in the redirect cycle so a fetch
   // from the old stream can never be issued alongside a flush.
   assign req_valid_out  = !rst_in && !flush_in && !outstanding_q && (count_q <= 3'd2);
   assign req_addr_out   = rst_in ? c_reset_fetch : fetch_pc_q;
   assign w_req_fire     = req_valid_out && req_ready_in;

   // Instruction outputs depend on registered state (reset only forces them).
   assign inst_valid_out = !rst_in && w_inst_avail;
   assign inst_out       = rst_in   ? 32'h0000_0000 :
                           w_head_c ? {16'h0000, buf_q[0]} : {buf_q[1], buf_q[0]};
   assign inst_pc_out    = rst_in ? c_reset_head : head_pc_q;
   assign inst_is_c_out  = rst_in ? 1'b1 : w_head_c;

   // Queue shift by the number of halfwords consumed this cycle.
   always_comb begin
      w_shift = buf_q;
      case (w_cons_n)
         3'd1: begin
            w_shift[0] = buf_q[1];
            w_shift[1] = buf_q[2];
            w_shift[2] = buf_q[3];
            w_shift[3] = 16'h0000;
         end
         3'd2: begin
            w_shift[0] = buf_q[2];
            w_shift[1] = buf_q[3];
            w_shift[2] = 16'h0000;
            w_shift[3] = 16'h0000;
         end
         default: ;
      endcase
   end

   // Next-state: append after shift, track request/response, flush overrides.
   always_comb begin
      buf_d         = w_shift;
      count_d       = count_q - w_cons_n + w_app_n;
      head_pc_d     = head_pc_q + {29'd0, w_cons_n[1:0], 1'b0};
      fetch_pc_d    = fetch_pc_q;
      skip_low_d    = skip_low_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;

      for (int i = 0; i < 4; i++) begin
         if ((w_app_n != 3'd0) && (3'(i) == w_base)) begin
            buf_d[i] = w_app0;
         end
         if ((w_app_n == 3'd2) && (3'(i) == (w_base + 3'd1))) begin
            buf_d[i] = w_app1;
         end
      end

      if (w_resp_take && skip_low_q) begin
         skip_low_d = 1'b0;
      end

      // Any response (kept or dropped) retires the single in-flight request.
      if (resp_valid_in) begin
         outstanding_d = 1'b0;
         discard_d     = 1'b0;
      end

      if (w_req_fire) begin
         outstanding_d = 1'b1;
         fetch_pc_d    = fetch_pc_q + 32'd4;
      end

      if (flush_in) begin
         buf_d      = buf_q;
         count_d    = 3'd0;
         head_pc_d  = flush_pc_in & 32'hFFFF_FFFE;
         fetch_pc_d = flush_pc_in & 32'hFFFF_FFFC;
         skip_low_d = flush_pc_in[1];
         if (resp_valid_in) begin
            outstanding_d = 1'b0;
            discard_d     = 1'b0;
         end else if (outstanding_q) begin
            // The stale response is still coming back; drop it on arrival.
            outstanding_d = 1'b1;
            discard_d     = 1'b1;
         end else begin
            outstanding_d = 1'b0;
            discard_d     = 1'b0;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < 4; i++) begin
            buf_q[i] <= 16'h0000;
         end
         count_q       <= 3'd0;
         head_pc_q     <= c_reset_head;
         fetch_pc_q    <= c_reset_fetch;
         skip_low_q    <= c_reset_skip;
         outstanding_q <= 1'b0;
         discard_q     <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            buf_q[i] <= buf_d[i];
         end
         count_q       <= count_d;
         head_pc_q     <= head_pc_d;
         fetch_pc_q    <= fetch_pc_d;
         skip_low_q    <= skip_low_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end
   end

endmodule
`default_nettype wire
